// File: rtl/booth2_pkg.sv
// Shared types and Booth radix-4 code definitions for the sequential Booth encoder.
// The weight function is shared with the verification model.
package booth2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [2:0] CODE_P0  = 3'b000;
    localparam logic [2:0] CODE_P1A = 3'b001;
    localparam logic [2:0] CODE_P1B = 3'b010;
    localparam logic [2:0] CODE_P2  = 3'b011;
    localparam logic [2:0] CODE_M2  = 3'b100;
    localparam logic [2:0] CODE_M1A = 3'b101;
    localparam logic [2:0] CODE_M1B = 3'b110;
    localparam logic [2:0] CODE_M0  = 3'b111;

    // Signed multiple of A selected by one Booth triplet.
    function automatic logic signed [2:0] booth2_weight(input logic [2:0] code);
        logic signed [2:0] w;
        case (code)
            CODE_P1A, CODE_P1B: w = 3'sb001;
            CODE_P2:            w = 3'sb010;
            CODE_M2:            w = 3'sb110;
            CODE_M1A, CODE_M1B: w = 3'sb111;
            default:            w = 3'sb000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/booth2_code_seq_if.sv
// Operand-in / Booth-group-out handshake bundle for booth2_code_seq.
// slave is the encoder's view, master is the producer/consumer view.
interface booth2_code_seq_if #(
    parameter int WIDTH = 16
);
    localparam int NGRP = WIDTH / 2;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       code_out;
    logic [GW-1:0]    grp_idx;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH:0]   neg_a_out;
    logic             zero_pp;
    logic             out_last;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, code_out, grp_idx, a_out, neg_a_out, zero_pp, out_last
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, code_out, grp_idx, a_out, neg_a_out, zero_pp, out_last
    );

endinterface

// File: rtl/booth2_neg.sv
// Combinational (WIDTH+1)-bit negator: -{A[MSB], A}. The extra bit means
// the most negative A negates without overflow.
module booth2_neg #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH:0]   neg_a
);

    assign neg_a = ~{a[WIDTH-1], a} + (WIDTH + 1)'(1);

endmodule

// File: rtl/booth2_code_seq.sv
// Sequential radix-4 Booth encoder: latches A and B, registers -A, then
// streams the NGRP Booth triplets of B one per output handshake.
module booth2_code_seq
    import booth2_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    booth2_code_seq_if.slave   bus
);

    localparam int            NGRP     = WIDTH / 2;
    localparam int            GW       = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   neg_a_q, neg_a_d;
    logic [WIDTH:0]   neg_a_calc;
    logic [WIDTH:0]   sr_q, sr_d;
    logic [GW-1:0]    grp_q, grp_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    booth2_neg #(.WIDTH(WIDTH)) u_neg (
        .a     (a_q),
        .neg_a (neg_a_calc)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        neg_a_d = neg_a_q;
        sr_d    = sr_q;
        grp_d   = grp_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a_in;
                    sr_d    = {bus.b_in, 1'b0};
                    grp_d   = '0;
                    state_d = NEG;
                end
            end
            NEG: begin
                neg_a_d = neg_a_calc;
                state_d = EMIT;
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (grp_q == LAST_GRP) begin
                        state_d = IDLE;
                    end else begin
                        // Arithmetic shift keeps B's sign as the upper triplet bits.
                        sr_d  = {{2{sr_q[WIDTH]}}, sr_q[WIDTH:2]};
                        grp_d = grp_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            neg_a_q     <= '0;
            sr_q        <= '0;
            grp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            neg_a_q     <= neg_a_d;
            sr_q        <= sr_d;
            grp_q       <= grp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.code_out  = sr_q[2:0];
    assign bus.grp_idx   = grp_q;
    assign bus.a_out     = a_q;
    assign bus.neg_a_out = neg_a_q;
    assign bus.zero_pp   = (sr_q[2:0] == CODE_P0) || (sr_q[2:0] == CODE_M0);
    assign bus.out_last  = (grp_q == LAST_GRP);

endmodule

// File: tb/tb_booth2_code_seq.sv
// Scoreboard bench for booth2_code_seq: directed operand pairs with
// hand-computed Booth codes and negations, backpressure and mid-op reset.
module tb_booth2_code_seq;
    import booth2_pkg::*;

    localparam int WIDTH = 16;
    localparam int NGRP  = WIDTH / 2;

    typedef struct {
        logic [2:0]  code;
        logic [2:0]  grp;
        logic [15:0] a;
        logic [16:0] neg;
        logic [15:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    booth2_code_seq_if #(.WIDTH(WIDTH)) bus ();

    booth2_code_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected group per output handshake, checks stall stability.
    initial begin : monitor
        exp_t        e;
        int          sum;
        int          w;
        int          bval;
        bit          stall;
        logic [2:0]  s_code;
        logic [2:0]  s_grp;
        logic [15:0] s_a;
        logic [16:0] s_neg;
        logic        s_zero;
        logic        s_last;
        sum   = 0;
        stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
                continue;
            end
            if (stall) begin
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_code", bus.code_out, s_code);
                check("stall_grp", bus.grp_idx, s_grp);
                check("stall_a", bus.a_out, s_a);
                check("stall_neg", bus.neg_a_out, s_neg);
                check("stall_zero", bus.zero_pp, s_zero);
                check("stall_last", bus.out_last, s_last);
            end
            if (bus.out_valid && !bus.out_ready) begin
                stall  = 1;
                s_code = bus.code_out;
                s_grp  = bus.grp_idx;
                s_a    = bus.a_out;
                s_neg  = bus.neg_a_out;
                s_zero = bus.zero_pp;
                s_last = bus.out_last;
            end else begin
                stall = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got grp %0d code %0b expected none", bus.grp_idx, bus.code_out);
                end else begin
                    e = q.pop_front();
                    check("code", bus.code_out, e.code);
                    check("grp_idx", bus.grp_idx, e.grp);
                    check("a_out", bus.a_out, e.a);
                    check("neg_a_out", bus.neg_a_out, e.neg);
                    check("zero_pp", bus.zero_pp, (e.code == CODE_P0) || (e.code == CODE_M0));
                    check("out_last", bus.out_last, e.grp == 3'd7);
                    if (e.grp == 3'd0) sum = 0;
                    w    = booth2_weight(bus.code_out);
                    sum += w * (1 << (2 * int'(e.grp)));
                    if (e.grp == 3'd7) begin
                        bval = $signed(e.b);
                        check("weighted_sum", sum, bval);
                    end
                end
            end
        end
    end

    // Issue one pair; codes holds g7..g0 packed, three bits each.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [23:0] codes,
                        input logic [16:0] neg, input bit busy_junk);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                check("in_ready_timeout", 1'b0, 1'b1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        for (int i = 0; i < NGRP; i++) begin
            e.code = codes[3*i +: 3];
            e.grp  = 3'(i);
            e.a    = a;
            e.neg  = neg;
            e.b    = b;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (busy_junk) begin
            bus.a_in = 16'hDEAD;
            bus.b_in = 16'hBEEF;
        end else begin
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("lat_neg_valid", bus.out_valid, 1'b0);
        check("lat_neg_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        check("lat_first_valid", bus.out_valid, 1'b1);
        if (busy_junk) begin
            repeat (3) @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", q.size(), 0);
        @(posedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        bit hit;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_zero_pp", bus.zero_pp, 1'b1);
        check("rst_code", bus.code_out, 3'b000);
        check("rst_grp", bus.grp_idx, 3'd0);
        check("rst_a_out", bus.a_out, 16'h0);
        check("rst_neg_a", bus.neg_a_out, 17'h0);

        // Small positive pair, in_valid kept high with junk while busy.
        send(16'h0005, 16'h0003, 24'h00000E, 17'h1FFFB, 1'b1);
        drain();
        // Most negative A and B.
        send(16'h8000, 16'h8000, 24'h800000, 17'h08000, 1'b0);
        drain();
        // B = -1.
        send(16'h1234, 16'hFFFF, 24'hFFFFFE, 17'h1EDCC, 1'b0);
        drain();
        // A = -1, B = max positive.
        send(16'hFFFF, 16'h7FFF, 24'h7FFFFE, 17'h00001, 1'b0);
        drain();
        // All zero.
        send(16'h0000, 16'h0000, 24'h000000, 17'h00000, 1'b0);
        drain();

        // Backpressure: stall 3 cycles while group 2 is presented.
        send(16'h7FFF, 16'h5A5A, 24'h4EC4EC, 17'h18001, 1'b0);
        hit = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid && bus.grp_idx == 3'd2) begin
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                hit = 1;
                break;
            end
        end
        check("stall_reached", hit, 1'b1);
        drain();

        // Reset during EMIT at group 4, with an input offered in the reset cycle.
        send(16'h0ABC, 16'h1234, 24'h08C390, 17'h1F544, 1'b0);
        hit = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.grp_idx == 3'd4) begin
                hit = 1;
                break;
            end
        end
        check("grp4_reached", hit, 1'b1);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a_in     = 16'h5555;
        bus.b_in     = 16'h5555;
        q.delete();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_grp", bus.grp_idx, 3'd0);
        check("mid_rst_a_out", bus.a_out, 16'h0);

        send(16'h0001, 16'h0001, 24'h000002, 17'h1FFFF, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        check("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
